// File: rtl/mult_seq_hs.sv
// Sequential integer multiplier with a valid/ready handshake on both sides.
// Retires BITS_PER_CYCLE multiplier bits per cycle, LSB first; operands can be signed or unsigned per transaction.
module mult_seq_hs #(
    parameter int IN_SIZE_0      = 4,
    parameter int IN_SIZE_1      = 8,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [IN_SIZE_0-1:0]           in_0_i,
    input  logic [IN_SIZE_1-1:0]           in_1_i,
    input  logic                           sign_0_i,
    input  logic                           sign_1_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [IN_SIZE_0+IN_SIZE_1-1:0] out_o,
    output logic                           busy_o
);

    localparam int OUT_SIZE = IN_SIZE_0 + IN_SIZE_1;
    localparam int N_STEPS  = IN_SIZE_1 / BITS_PER_CYCLE;
    localparam int CW       = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int AW       = OUT_SIZE + 1;

    if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > IN_SIZE_1 ||
        (IN_SIZE_1 % BITS_PER_CYCLE) != 0) begin : g_bad_param
        $fatal(1, "mult_seq_hs: BITS_PER_CYCLE must be in 1..IN_SIZE_1 and divide IN_SIZE_1");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [AW-1:0]             r_acc;
    logic [AW-1:0]             r_a_sh;
    logic [IN_SIZE_1-1:0]      r_b;
    logic                      r_sign_1;
    logic [CW-1:0]             r_cnt;
    logic [OUT_SIZE-1:0]       r_out;

    logic                      w_accept;
    logic                      w_last;
    logic [AW-1:0]             w_a_ext;
    logic [BITS_PER_CYCLE-1:0] w_chunk;
    logic                      w_chunk_neg;
    logic [AW-1:0]             w_chunk_ext;
    logic [AW-1:0]             w_pp;
    logic [AW-1:0]             w_acc_next;

    assign w_accept = in_valid_i & in_ready_o;
    assign w_last   = (r_cnt == CW'(N_STEPS - 1));

    assign w_a_ext = sign_0_i ? {{(AW-IN_SIZE_0){in_0_i[IN_SIZE_0-1]}}, in_0_i}
                              : {{(AW-IN_SIZE_0){1'b0}}, in_0_i};

    // On the final step of a signed B, the top chunk is read as two's complement,
    // which gives B's MSB its negative weight. Modular arithmetic keeps the rest exact.
    assign w_chunk     = r_b[BITS_PER_CYCLE-1:0];
    assign w_chunk_neg = r_sign_1 & w_last & w_chunk[BITS_PER_CYCLE-1];
    assign w_chunk_ext = {{(AW-BITS_PER_CYCLE){w_chunk_neg}}, w_chunk};
    assign w_pp        = r_a_sh * w_chunk_ext;
    assign w_acc_next  = r_acc + w_pp;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_BUSY;
            S_BUSY: if (w_last)   w_state_next = S_DONE;
            S_DONE: if (out_ready_i) w_state_next = w_accept ? S_BUSY : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (r_state)
            S_IDLE: in_ready_o = rst_ni;
            S_BUSY: busy_o = 1'b1;
            S_DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                in_ready_o  = rst_ni & out_ready_i;
            end
            default: ;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right, so each step sees its chunk at bit 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_acc    <= '0;
            r_a_sh   <= '0;
            r_b      <= '0;
            r_sign_1 <= 1'b0;
            r_cnt    <= '0;
            r_out    <= '0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_a_sh   <= w_a_ext;
            r_b      <= in_1_i;
            r_sign_1 <= sign_1_i;
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc  <= w_acc_next;
            r_a_sh <= r_a_sh << BITS_PER_CYCLE;
            r_b    <= r_b >> BITS_PER_CYCLE;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) r_out <= w_acc_next[OUT_SIZE-1:0];
        end
    end

    assign out_o = r_out;

endmodule

// File: tb/tb_mult_seq_hs.sv
// Bench for mult_seq_hs: four instances (BITS_PER_CYCLE 1,2,4,8) on shared inputs;
// handshake scenarios use the BITS_PER_CYCLE=2 instance, products are checked against an integer model.
module tb_mult_seq_hs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_0 = '0;
    logic [7:0]  in_1 = '0;
    logic        sign_0 = 1'b0;
    logic        sign_1 = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_w  [4];
    logic        out_valid_w [4];
    logic        busy_w      [4];
    logic [11:0] out_w       [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        mult_seq_hs #(
            .IN_SIZE_0     (4),
            .IN_SIZE_1     (8),
            .BITS_PER_CYCLE(1 << gi)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready_w[gi]),
            .in_0_i     (in_0),
            .in_1_i     (in_1),
            .sign_0_i   (sign_0),
            .sign_1_i   (sign_1),
            .out_valid_o(out_valid_w[gi]),
            .out_ready_i(out_ready),
            .out_o      (out_w[gi]),
            .busy_o     (busy_w[gi])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Exact product of the interpreted operands, reduced to the 12-bit output.
    function automatic logic [11:0] model(input logic [3:0] a, input logic [7:0] b,
                                          input logic s0, input logic s1);
        int av, bv;
        av = s0 ? int'($signed(a)) : int'(a);
        bv = s1 ? int'($signed(b)) : int'(b);
        return 12'(av * bv);
    endfunction

    // One transaction through all four instances; they are held in DONE until every one has finished.
    task automatic txn(input logic [3:0] a, input logic [7:0] b, input logic s0, input logic s1);
        logic [11:0] exp;
        exp = model(a, b, s0, s1);
        in_0 = a; in_1 = b; sign_0 = s0; sign_1 = s1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_0 = ~a; in_1 = ~b;
        for (int i = 0; i < 8; i++) step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("txn_valid[%0d]", k), 32'(out_valid_w[k]), 32'd1);
            chk($sformatf("txn_out[%0d]", k), 32'(out_w[k]), 32'(exp));
        end
        $display("txn a=%h b=%h s0=%0d s1=%0d exp=%h", a, b, s0, s1, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_valid", 32'(out_valid_w[1]), 32'd0);
        chk("rst_busy", 32'(busy_w[1]), 32'd0);
        chk("rst_out", 32'(out_w[1]), 32'd0);
        chk("rst_in_ready", 32'(in_ready_w[1]), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready_w[1]), 32'd1);

        // Signed boundary, latency of exactly N_STEPS edges
        in_0 = 4'h8; in_1 = 8'h80; sign_0 = 1'b1; sign_1 = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("lat_valid_e%0d", i), 32'(out_valid_w[1]), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("bound_out", 32'(out_w[1]), 32'h400);

        // Backpressure: output held, input side closed, stray valids ignored
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_0 = 4'(i); in_1 = 8'(i * 17);
            #1;
            chk("bp_in_ready", 32'(in_ready_w[1]), 32'd0);
            step();
            chk("bp_valid", 32'(out_valid_w[1]), 32'd1);
            chk("bp_out", 32'(out_w[1]), 32'h400);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("done_in_ready", 32'(in_ready_w[1]), 32'd1);
        step();
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid_w[1]), 32'd0);
        chk("post_hs_busy", 32'(busy_w[1]), 32'd0);
        chk("post_hs_out", 32'(out_w[1]), 32'h400);
        step();
        chk("post_hs_idle", 32'(out_valid_w[1]), 32'd0);

        // Directed products through every BITS_PER_CYCLE
        txn(4'hF, 8'hFF, 1'b0, 1'b0);
        chk("uu_15x255", 32'(out_w[1]), 32'hEF1);
        txn(4'h8, 8'hFF, 1'b1, 1'b0);
        chk("su_m8x255", 32'(out_w[1]), 32'h808);
        txn(4'h8, 8'h80, 1'b1, 1'b1);
        txn(4'h0, 8'h00, 1'b1, 1'b1);
        txn(4'hF, 8'h80, 1'b0, 1'b1);

        // Back-to-back: in_valid and out_ready held high
        in_0 = 4'd3; in_1 = 8'd5; sign_0 = 1'b0; sign_1 = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_0 = 4'hF; in_1 = 8'd2; sign_0 = 1'b1; sign_1 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("b2b_first_valid", 32'(out_valid_w[1]), 32'd1);
        chk("b2b_first_out", 32'(out_w[1]), 32'd15);
        step();
        chk("b2b_no_idle_busy", 32'(busy_w[1]), 32'd1);
        chk("b2b_gap_valid", 32'(out_valid_w[1]), 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("b2b_second_valid", 32'(out_valid_w[1]), 32'd1);
        chk("b2b_second_out", 32'(out_w[1]), 32'hFFE);
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;

        // Reset during BUSY aborts the transaction
        in_0 = 4'd7; in_1 = 8'd9; sign_0 = 1'b0; sign_1 = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_valid", 32'(out_valid_w[1]), 32'd0);
        chk("abort_busy", 32'(busy_w[1]), 32'd0);
        #1;
        chk("abort_in_ready", 32'(in_ready_w[1]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_no_valid", 32'(out_valid_w[1]), 32'd0);
        end

        // Random operands across all sign modes
        for (int t = 0; t < 1000; t++) begin
            txn(4'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
